// File: rtl/even_parity_pkg.sv
// Shared types and helpers for the even-parity frame checker and its benches.
package even_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 16;

    // XOR reduction: 1 when the vector holds an odd number of ones.
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/parity_accum.sv
// One-bit running XOR register; clear has priority over load, load over accumulate.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic acc,
    input  logic d,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 1'b0;
        end else if (clr) begin
            q_reg <= 1'b0;
        end else if (load) begin
            q_reg <= d;
        end else if (acc) begin
            q_reg <= q_reg ^ d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/even_parity_frame_checker.sv
// Serial even-parity frame checker: DATA_W data bits LSB first, then one parity bit.
// Define PARITY_ERR_CNT_EN to add the saturating err_count output.
module even_parity_frame_checker
    import even_parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic                 in_bit,
`ifdef PARITY_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_count,
`endif
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic               out_valid_reg;
    logic               parity_err_reg;
    logic               frame_abort_reg;
    logic               busy_reg;

    logic start_acc, data_acc, par_acc, abort;
    logic acc_q;
    logic frame_err;

    // A qualified start always wins: it restarts the frame from any state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        start_acc  = 1'b0;
        data_acc   = 1'b0;
        par_acc    = 1'b0;
        abort      = 1'b0;
        if (in_valid) begin
            if (in_start) begin
                start_acc  = 1'b1;
                abort      = (state_reg != IDLE);
                state_next = DATA;
                cnt_next   = CNT_W'(1);
            end else begin
                case (state_reg)
                    DATA: begin
                        data_acc = 1'b1;
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                            state_next = PARITY;
                        end
                    end
                    PARITY: begin
                        par_acc    = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign frame_err = even_parity(32'({acc_q, in_bit}));

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (par_acc),
        .load  (start_acc),
        .acc   (data_acc),
        .d     (in_bit),
        .q     (acc_q)
    );

    // Each shift bit loads only at its own counter position.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_reg[gi] <= 1'b0;
                end else if (start_acc) begin
                    shift_reg[gi] <= (gi == 0) ? in_bit : 1'b0;
                end else if (data_acc && (cnt_reg == CNT_W'(gi))) begin
                    shift_reg[gi] <= in_bit;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            parity_err_reg  <= 1'b0;
            frame_abort_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            out_valid_reg   <= par_acc;
            frame_abort_reg <= abort;
            busy_reg        <= (state_next != IDLE);
            if (par_acc) begin
                out_data_reg   <= shift_reg;
                parity_err_reg <= frame_err;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign parity_err  = parity_err_reg;
    assign frame_abort = frame_abort_reg;
    assign busy        = busy_reg;

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // Updated alongside out_valid so the count already includes the frame being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (par_acc && frame_err && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_reg;
`endif

endmodule

// File: tb/tb_even_parity_frame_checker.sv
// Self-checking bench for even_parity_frame_checker (DATA_W = 8), vector table plus scoreboard.
module tb_even_parity_frame_checker;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_start;
    logic              in_bit;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              parity_err;
    logic              frame_abort;
    logic              busy;
`ifdef PARITY_ERR_CNT_EN
    logic [15:0]       err_count;
    int                exp_err_count;
`endif

    even_parity_frame_checker #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_start    (in_start),
        .in_bit      (in_bit),
`ifdef PARITY_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .out_valid   (out_valid),
        .out_data    (out_data),
        .parity_err  (parity_err),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              par;
        logic              exp_err;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;
    int   n_abort = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && frame_abort) n_abort++;
        if (rst_n && out_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got data %0h with no frame pending at %0t",
                         out_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("parity_err", 32'(parity_err), 32'(e.err));
                $display("frame out: data=%02h parity_err=%0b", out_data, parity_err);
`ifdef PARITY_ERR_CNT_EN
                if (e.err && exp_err_count < 16'hFFFF) exp_err_count++;
                chk("err_count", 32'(err_count), 32'(exp_err_count));
`endif
            end
        end
    end

    task automatic send_bit(input logic start, input logic b);
        in_valid = 1'b1;
        in_start = start;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expectation is pushed just before the parity bit so an early out_valid finds an empty queue.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic exp_err);
        exp_t e;
        for (int i = 0; i < DATA_W; i++) send_bit(i == 0, d[i]);
        e.data = d;
        e.err  = exp_err;
        exp_q.push_back(e);
        send_bit(1'b0, par);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"},   32'(out_valid),   32'd0);
        chk({tag, "_out_data"},    32'(out_data),    32'd0);
        chk({tag, "_parity_err"},  32'(parity_err),  32'd0);
        chk({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   v0;
`ifdef PARITY_ERR_CNT_EN
        exp_err_count = 0;
`endif
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1};

        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
        rst_n    = 1'b0;
        idle(2);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        // Data bit without start in IDLE is ignored.
        send_bit(1'b0, 1'b1);
        chk("idle_no_start_busy", 32'(busy), 32'd0);

        // Table-driven frames with an idle gap between them.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].exp_err);
            chk($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            idle(2);
        end

        // Frame 0x3C with stalls between bits 4/5 and between bit 7 and parity.
        v0 = n_valid;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        idle(3);
        chk("stall_busy", 32'(busy), 32'd1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        idle(3);
        chk("stall_no_early_valid", 32'(n_valid - v0), 32'd0);
        e.data = 8'h3C;
        e.err  = 1'b0;
        exp_q.push_back(e);
        send_bit(1'b0, 1'b0);
        idle(2);
        chk("stall_one_valid", 32'(n_valid - v0), 32'd1);

        // Abort: four bits then a new start carrying 0xFF.
        v0 = n_valid;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0);
        idle(2);
        chk("abort_pulses", 32'(n_abort), 32'd1);
        chk("abort_one_valid", 32'(n_valid - v0), 32'd1);

        // Back-to-back frames.
        v0 = n_valid;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        idle(2);
        chk("b2b_two_valids", 32'(n_valid - v0), 32'd2);

        // Reset mid-frame after five bits.
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midreset");
`ifdef PARITY_ERR_CNT_EN
        exp_err_count = 0;
        chk("midreset_err_count", 32'(err_count), 32'd0);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(1);
        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b0);
        idle(2);
        chk("reset_no_abort", 32'(n_abort), 32'd1);
        chk("reset_one_valid", 32'(n_valid - v0), 32'd1);
        chk("reset_data_held", 32'(out_data), 32'h55);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
